uart_tx_cfg: RTL and testbench

UART_TX_CFG -- requirements
Module: uart_tx_cfg

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_bit_timer.sv | 35 +++
 rtl/uart_tx_cfg.sv | 135 +++++++++++++
 tb/tb_uart_tx_cfg.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode codes and transmitter FSM state encoding.
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      PAR   = 3'd3,
      STOP  = 3'd4
   } state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Baud tick generator: counts clk cycles while en, bit_end pulses on count CLK_DIV-1.
// Zero-latency bit_end from the registered count; restart holds the count at zero.
module uart_bit_timer #(
   parameter int CLK_DIV = 434
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   input  logic en,
   output logic bit_end
);
   localparam int            CW   = $clog2(CLK_DIV);
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign bit_end = en && (cnt_q == LAST);

   // Wrapping to zero on bit_end keeps every bit exactly CLK_DIV cycles long.
   always_comb begin
      cnt_d = cnt_q;
      if (restart)
         cnt_d = '0;
      else if (en)
         cnt_d = bit_end ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with a one-entry holding register; tx falls 2 cycles after accept.
// Backpressure: tx_ready = !hold_full; a strobe while not ready is dropped and flagged on tx_ovf.
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int CLK_DIV   = 434,
   parameter int DATA_W    = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              tx_en,
   input  logic [DATA_W-1:0] tx_dat,
   output logic              tx_ready,
   output logic              tx,
   output logic              busy,
   output logic              tx_done,
   output logic              tx_ovf
);
   state_e              state_q, state_d;
   logic                hold_full_q, hold_full_d;
   logic [DATA_W-1:0]   hold_dat_q, hold_dat_d;
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic                par_q, par_d;
   logic [2:0]          bit_cnt_q, bit_cnt_d;
   logic                stop_cnt_q, stop_cnt_d;
   logic                tx_q, tx_d;
   logic                tx_done_q, tx_done_d;
   logic                tx_ovf_q, tx_ovf_d;
   logic                load, unload, bit_end;

   uart_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .restart (state_q == IDLE),
      .en      (state_q != IDLE),
      .bit_end (bit_end)
   );

   always_comb begin
      load       = tx_en && !hold_full_q;
      unload     = 1'b0;
      state_d    = state_q;
      shift_d    = shift_q;
      par_d      = par_q;
      bit_cnt_d  = bit_cnt_q;
      stop_cnt_d = stop_cnt_q;
      tx_done_d  = 1'b0;
      unique case (state_q)
         IDLE:  if (hold_full_q) begin
                   state_d = START;
                   unload  = 1'b1;
                end
         START: if (bit_end) begin
                   state_d   = DATA;
                   bit_cnt_d = '0;
                end
         DATA:  if (bit_end) begin
                   shift_d   = shift_q >> 1;
                   bit_cnt_d = bit_cnt_q + 3'd1;
                   if (bit_cnt_q == 3'(DATA_W - 1))
                      state_d = (PARITY != PAR_NONE) ? PAR : STOP;
                end
         PAR:   if (bit_end)
                   state_d = STOP;
         STOP:  if (bit_end) begin
                   if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                      tx_done_d = 1'b1;
                      // A held word chains straight into the next start bit.
                      if (hold_full_q) begin
                         state_d = START;
                         unload  = 1'b1;
                      end else begin
                         state_d = IDLE;
                      end
                   end else begin
                      stop_cnt_d = 1'b1;
                   end
                end
         default: state_d = IDLE;
      endcase
      if (unload) begin
         shift_d    = hold_dat_q;
         par_d      = (^hold_dat_q) ^ (PARITY == PAR_ODD);
         stop_cnt_d = 1'b0;
      end
   end

   always_comb begin
      hold_dat_d  = load ? tx_dat : hold_dat_q;
      hold_full_d = load || (hold_full_q && !unload);
      tx_ovf_d    = tx_en && hold_full_q;
      tx_d        = 1'b1;
      unique case (state_q)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_q[0];
         PAR:     tx_d = par_q;
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         hold_full_q <= 1'b0;
         hold_dat_q  <= '0;
         shift_q     <= '0;
         par_q       <= 1'b0;
         bit_cnt_q   <= '0;
         stop_cnt_q  <= 1'b0;
         tx_q        <= 1'b1;
         tx_done_q   <= 1'b0;
         tx_ovf_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_full_q <= hold_full_d;
         hold_dat_q  <= hold_dat_d;
         shift_q     <= shift_d;
         par_q       <= par_d;
         bit_cnt_q   <= bit_cnt_d;
         stop_cnt_q  <= stop_cnt_d;
         tx_q        <= tx_d;
         tx_done_q   <= tx_done_d;
         tx_ovf_q    <= tx_ovf_d;
      end
   end

   assign tx_ready = !hold_full_q;
   assign tx       = tx_q;
   assign busy     = (state_q != IDLE) || hold_full_q;
   assign tx_done  = tx_done_q;
   assign tx_ovf   = tx_ovf_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Four differently configured transmitters; a line monitor decodes every frame and checks it
// against words queued by the stimulus, using a frame model built from the UART framing rules.
module tb_uart_tx_cfg;

   localparam int CD_T [4] = '{4, 4, 4, 434};
   localparam int W_T  [4] = '{8, 8, 5, 8};
   localparam int P_T  [4] = '{2, 1, 0, 0};
   localparam int S_T  [4] = '{1, 1, 2, 1};

   logic            clk = 1'b0;
   logic [3:0]      rst_n_v;
   logic [3:0]      tx_en_v;
   logic [3:0][7:0] tx_dat_p;
   logic [3:0]      ready_v, tx_v, busy_v, done_v, ovf_v;

   int chk = 0;
   int err = 0;
   int cyc = 0;

   logic [7:0]  exp_q [4][$];
   int          done_cnt [4];
   int          ovf_cnt [4];
   int          start_cyc [4];
   int          prev_start [4];
   int          pos [4];
   logic        in_f [4];
   logic [11:0] got_a [4];
   logic        steady [4];
   logic        done_ok [4];
   logic        done_bad [4];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      uart_tx_cfg #(
         .CLK_DIV(CD_T[g]), .DATA_W(W_T[g]), .PARITY(P_T[g]), .STOP_BITS(S_T[g])
      ) u_dut (
         .clk      (clk),
         .rst_n    (rst_n_v[g]),
         .tx_en    (tx_en_v[g]),
         .tx_dat   (tx_dat_p[g][W_T[g]-1:0]),
         .tx_ready (ready_v[g]),
         .tx       (tx_v[g]),
         .busy     (busy_v[g]),
         .tx_done  (done_v[g]),
         .tx_ovf   (ovf_v[g])
      );
   end

   function automatic int nbits(input int i);
      return 1 + W_T[i] + ((P_T[i] != 0) ? 1 : 0) + S_T[i];
   endfunction

   // Frame as line bits, index 0 first: start 0, data LSB first, parity, stop ones.
   function automatic logic [11:0] model_frame(input int i, input logic [7:0] d);
      logic [11:0] f;
      int ones;
      f = '1;
      f[0] = 1'b0;
      ones = 0;
      for (int k = 0; k < W_T[i]; k++) begin
         f[1+k] = d[k];
         ones += int'(d[k]);
      end
      if (P_T[i] == 2)      f[1+W_T[i]] = 1'(ones % 2);
      else if (P_T[i] == 1) f[1+W_T[i]] = (ones % 2 == 0);
      return f;
   endfunction

   task automatic chk1(input string name, input logic [31:0] act, input logic [31:0] req);
      chk++;
      if (act !== req) begin
         err++;
         $display("FAIL %s actual %0h required %0h", name, act, req);
      end
   endtask

   task automatic check_frame(input int i);
      logic [7:0] d;
      if (exp_q[i].size() == 0) begin
         chk++;
         err++;
         $display("FAIL frame_unexpected inst %0d actual %h required none", i, got_a[i]);
      end else begin
         d = exp_q[i].pop_front();
         chk1($sformatf("frame_bits inst %0d word %h", i, d), 32'(got_a[i]), 32'(model_frame(i, d)));
         chk1($sformatf("bit_width inst %0d", i), 32'(steady[i]), 32'd1);
         chk1($sformatf("done_pos inst %0d", i), 32'(done_ok[i] && !done_bad[i]), 32'd1);
      end
   endtask

   // Line monitor: one frame = nbits*CLK_DIV cycles starting at the first low sample.
   initial begin
      for (int i = 0; i < 4; i++) begin
         in_f[i] = 1'b0; done_cnt[i] = 0; ovf_cnt[i] = 0; start_cyc[i] = 0; prev_start[i] = 0;
      end
      forever begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            if (done_v[i]) done_cnt[i]++;
            if (ovf_v[i]) ovf_cnt[i]++;
            if (!rst_n_v[i]) begin
               in_f[i] = 1'b0;
            end else begin
               if (!in_f[i] && !tx_v[i]) begin
                  in_f[i] = 1'b1; pos[i] = 0; got_a[i] = '1; steady[i] = 1'b1;
                  done_ok[i] = 1'b0; done_bad[i] = 1'b0;
                  prev_start[i] = start_cyc[i]; start_cyc[i] = cyc;
               end
               if (in_f[i]) begin
                  if (pos[i] % CD_T[i] == 0) got_a[i][pos[i] / CD_T[i]] = tx_v[i];
                  else if (tx_v[i] !== got_a[i][pos[i] / CD_T[i]]) steady[i] = 1'b0;
                  if (done_v[i]) begin
                     if (pos[i] == nbits(i) * CD_T[i] - 1) done_ok[i] = 1'b1;
                     else done_bad[i] = 1'b1;
                  end
                  pos[i]++;
                  if (pos[i] == nbits(i) * CD_T[i]) begin
                     in_f[i] = 1'b0;
                     check_frame(i);
                  end
               end
            end
         end
      end
   end

   task automatic send(input int i, input logic [7:0] d);
      int n;
      n = 0;
      while (!ready_v[i] && n < 10000) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 10000) begin
         chk++; err++;
         $display("FAIL ready_timeout inst %0d actual 0 required 1", i);
      end
      tx_en_v[i] = 1'b1;
      tx_dat_p[i] = d;
      exp_q[i].push_back(d & 8'((1 << W_T[i]) - 1));
      @(posedge clk); #1;
      tx_en_v[i] = 1'b0;
   endtask

   task automatic wait_idle(input int i);
      int n;
      n = 0;
      while ((busy_v[i] || !tx_v[i]) && n < 6000) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 6000) begin
         chk++; err++;
         $display("FAIL idle_timeout inst %0d actual busy required idle", i);
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      int d0, o0, lo, hi, gap, ri;
      logic [7:0] rd;
      rst_n_v = '0; tx_en_v = '0; tx_dat_p = '0;
      repeat (3) @(posedge clk);
      #1;
      chk1("rst_tx", 32'(tx_v), 32'hF);
      chk1("rst_ready", 32'(ready_v), 32'hF);
      chk1("rst_busy", 32'(busy_v), 32'h0);
      chk1("rst_done", 32'(done_v), 32'h0);
      chk1("rst_ovf", 32'(ovf_v), 32'h0);
      rst_n_v = '1;
      @(posedge clk); #1;

      // Even parity 0xA5, with start-bit latency
      d0 = done_cnt[0];
      send(0, 8'hA5);
      @(posedge clk); #1;
      chk1("lat_tx_high", 32'(tx_v[0]), 32'd1);
      @(posedge clk); #1;
      chk1("lat_tx_low", 32'(tx_v[0]), 32'd0);
      chk1("busy_in_frame", 32'(busy_v[0]), 32'd1);
      wait_idle(0);
      chk1("a5_done_count", 32'(done_cnt[0] - d0), 32'd1);

      send(1, 8'hA5);
      wait_idle(1);
      send(2, 8'h13);
      wait_idle(2);

      // Two words back to back: second start follows first stop directly
      d0 = done_cnt[0];
      send(0, 8'h55);
      send(0, 8'hAA);
      wait_idle(0);
      chk1("b2b_start_gap", 32'(start_cyc[0] - prev_start[0]), 32'd44);
      chk1("b2b_done_count", 32'(done_cnt[0] - d0), 32'd2);

      // Overflow: third strobe arrives while the second word is held
      o0 = ovf_cnt[0];
      send(0, 8'h01);
      send(0, 8'h02);
      chk1("ovf_ready_low", 32'(ready_v[0]), 32'd0);
      tx_en_v[0] = 1'b1;
      tx_dat_p[0] = 8'h03;
      @(posedge clk); #1;
      tx_en_v[0] = 1'b0;
      chk1("ovf_pulse", 32'(ovf_v[0]), 32'd1);
      wait_idle(0);
      chk1("ovf_count", 32'(ovf_cnt[0] - o0), 32'd1);

      // Reset in the middle of a frame
      send(0, 8'hF0);
      repeat (20) @(posedge clk);
      #1;
      chk1("pre_rst_tx", 32'(tx_v[0]), 32'd0);
      d0 = done_cnt[0];
      rst_n_v[0] = 1'b0;
      #1;
      chk1("mid_rst_tx", 32'(tx_v[0]), 32'd1);
      chk1("mid_rst_busy", 32'(busy_v[0]), 32'd0);
      chk1("mid_rst_ready", 32'(ready_v[0]), 32'd1);
      exp_q[0].delete();
      repeat (4) @(posedge clk);
      #1;
      rst_n_v[0] = 1'b1;
      repeat (50) @(posedge clk);
      #1;
      chk1("rst_no_done", 32'(done_cnt[0] - d0), 32'd0);
      send(0, 8'h3C);
      wait_idle(0);

      // Random words to random small-divider instances
      for (int k = 0; k < 12; k++) begin
         ri = int'($urandom_range(0, 2));
         rd = 8'($urandom);
         send(ri, rd);
         gap = int'($urandom_range(0, 30));
         if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
         end
      end
      for (int i = 0; i < 3; i++) wait_idle(i);

      // Full-rate divider: 9 low bits then stop, each 434 cycles
      send(3, 8'h00);
      lo = 0;
      while (tx_v[3] && lo < 100) begin
         @(negedge clk);
         lo++;
      end
      lo = 0;
      while (!tx_v[3] && lo < 5000) begin
         lo++;
         @(negedge clk);
      end
      chk1("div434_low_cycles", 32'(lo), 32'd3906);
      hi = 0;
      while (hi < 1000) begin
         hi++;
         if (done_v[3]) break;
         @(negedge clk);
      end
      chk1("div434_stop_cycles", 32'(hi), 32'd434);
      @(posedge clk); #1;
      wait_idle(3);

      for (int i = 0; i < 4; i++)
         chk1($sformatf("leftover_words inst %0d", i), 32'(exp_q[i].size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", chk, err);
      $finish;
   end

endmodule
